// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction-memory fetch controller
package imem_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } imem_state_t;

endpackage

// File: rtl/imem_next_pc.sv
// rtl/imem_next_pc.sv - combinational next-PC priority mux (halt > stall > jump > branch > pc+1)
//
// Ports:
//   pc                          current fetch address
//   halt_req, stall             hold the PC
//   jump, jump_target           redirect to jump_target
//   branch_taken, branch_target redirect to branch_target
//   pc_next                     address to load on the next edge while running
//   pc_plus1                    pc + 1, wrapping modulo 2^ADDR_W
module imem_next_pc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_plus1
);

    assign pc_plus1 = pc + ADDR_W'(1);

    always_comb begin
        pc_next = pc_plus1;
        if (halt_req || stall) begin
            pc_next = pc;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - program loader and PC sequencer for the 16-bit instruction memory
//
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (running XOR of loaded words on ld_checksum).
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   load_start, run_start         one-cycle mode pulses
//   ld_valid/ld_data/ld_last      loader word stream, ld_ready accepts
//   imem_we/imem_waddr/imem_wdata registered instruction-memory write port
//   stall/branch_*/jump*/halt_req core control while running
//   pc, pc_plus1, fetch_valid     fetch address and its qualifier
//   load_err                      sticky overflow flag for the last load
//   ld_checksum                   XOR of loaded words (0 when the feature is off)
//   state                         IDLE=0, LOAD=1, RUN=2, HALT=3
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                MEM_DEPTH = MEM_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic              run_start,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              fetch_valid,
    output logic              load_err,
    output logic [DATA_W-1:0] ld_checksum,
    output logic [1:0]        state
);

    // One extra bit so the counter can represent MEM_DEPTH itself.
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W + 1)'(MEM_DEPTH - 1);

    imem_state_t       state_q, state_d;
    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W-1:0] pc_next;
    logic              xfer;
    logic              cnt_clr;
    logic              load_done;
    logic              overflow;

    assign state       = state_q;
    assign ld_ready    = (state_q == ST_LOAD) && (wr_cnt < DEPTH_C);
    assign xfer        = ld_valid && ld_ready;
    assign fetch_valid = (state_q == ST_RUN);

    imem_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc            (pc),
        .halt_req      (halt_req),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .pc_plus1      (pc_plus1)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        load_done = 1'b0;
        overflow  = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    cnt_clr = 1'b1;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (ld_last) begin
                        state_d   = ST_IDLE;
                        load_done = 1'b1;
                    end else if (wr_cnt == DEPTH_M1) begin
                        // Memory full with no end marker: abandon the load.
                        state_d   = ST_IDLE;
                        load_done = 1'b1;
                        overflow  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            wr_cnt     <= '0;
            load_err   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= xfer;
            if (xfer) begin
                imem_waddr <= wr_cnt[ADDR_W-1:0];
                imem_wdata <= ld_data;
            end

            if (cnt_clr) begin
                wr_cnt <= '0;
            end else if (xfer) begin
                wr_cnt <= wr_cnt + (ADDR_W + 1)'(1);
            end

            if (cnt_clr) begin
                load_err <= 1'b0;
            end else if (overflow) begin
                load_err <= 1'b1;
            end

            if (load_done) begin
                pc <= RESET_PC;
            end else if (state_q == ST_RUN) begin
                pc <= pc_next;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else if (cnt_clr) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ ld_data;
        end
    end

    assign ld_checksum = csum_q;
`else
    assign ld_checksum = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - directed self-checking bench for imem_fetch_ctrl
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        imem_we;
    logic [15:0] imem_waddr;
    logic [15:0] imem_wdata;
    logic        run_start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [15:0] jump_target = '0;
    logic        halt_req = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        fetch_valid;
    logic        load_err;
    logic [15:0] ld_checksum;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          late_err = 0;
    logic        hs_prev = 1'b0;

    imem_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_last       (ld_last),
        .ld_ready      (ld_ready),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .run_start     (run_start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .pc_plus1      (pc_plus1),
        .fetch_valid   (fetch_valid),
        .load_err      (load_err),
        .ld_checksum   (ld_checksum),
        .state         (state)
    );

    always #5 clk = ~clk;

    // Write-port monitor: every write must follow a handshake seen one cycle earlier.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
            if (!hs_prev) late_err = late_err + 1;
        end
        hs_prev = ld_valid && ld_ready && !reset;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input logic last, output logic accepted);
        ld_data  = w;
        ld_last  = last;
        ld_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            if (ld_ready) accepted = 1'b1;
            tick();
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        late_err = 0;
    endtask

    logic [15:0] prog6 [6] = '{16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1, 16'hC07B};
    logic [15:0] prog4 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] exp_cs6;
    logic [15:0] exp_cs4;
    logic [15:0] exp_cs16;
    logic        acc;

    initial begin
`ifdef IMEM_LOAD_CHECKSUM_EN
        exp_cs6  = 16'h9146;
        exp_cs4  = 16'h4444;
        exp_cs16 = 16'h0000;
`else
        exp_cs6  = 16'h0000;
        exp_cs4  = 16'h0000;
        exp_cs16 = 16'h0000;
`endif

        // Reset values
        tick();
        tick();
        check("rst_state", state, 2'd0);
        check("rst_pc", pc, 16'h0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_we", imem_we, 1'b0);
        check("rst_waddr", imem_waddr, 16'h0);
        check("rst_wdata", imem_wdata, 16'h0);
        check("rst_fetch_valid", fetch_valid, 1'b0);
        check("rst_load_err", load_err, 1'b0);
        check("rst_checksum", ld_checksum, 16'h0);
        reset = 1'b0;
        tick();

        // Six-word back-to-back load
        pulse_load();
        check("ld6_state", state, 2'd1);
        check("ld6_ready", ld_ready, 1'b1);
        clear_log();
        for (int i = 0; i < 6; i++) begin
            send_word(prog6[i], i == 5, acc);
            check("ld6_acc", acc, 1'b1);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ld6_state_end", state, 2'd0);
        check("ld6_pc", pc, 16'h0);
        tick();
        tick();
        check("ld6_nwr", wr_addr_q.size(), 6);
        for (int i = 0; i < 6 && i < wr_addr_q.size(); i++) begin
            check("ld6_waddr", wr_addr_q[i], i);
            check("ld6_wdata", wr_data_q[i], prog6[i]);
        end
        check("ld6_timing", late_err, 0);
        check("ld6_checksum", ld_checksum, exp_cs6);

        // Load with ld_valid toggling every other cycle
        pulse_load();
        clear_log();
        for (int i = 0; i < 4; i++) begin
            send_word(prog4[i], i == 3, acc);
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            tick();
        end
        tick();
        check("ldt_state", state, 2'd0);
        check("ldt_nwr", wr_addr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check("ldt_waddr", wr_addr_q[i], i);
            check("ldt_wdata", wr_data_q[i], prog4[i]);
        end
        check("ldt_timing", late_err, 0);
        check("ldt_checksum", ld_checksum, exp_cs4);

        // Overflow: 17 words, no end marker
        pulse_load();
        clear_log();
        for (int i = 0; i < 16; i++) begin
            send_word(16'hA000 + 16'(i), 1'b0, acc);
            check("ovf_acc", acc, 1'b1);
        end
        check("ovf_state", state, 2'd0);
        check("ovf_ready", ld_ready, 1'b0);
        check("ovf_err", load_err, 1'b1);
        send_word(16'hA010, 1'b0, acc);
        check("ovf_17th_rejected", acc, 1'b0);
        ld_valid = 1'b0;
        tick();
        check("ovf_nwr", wr_addr_q.size(), 16);
        check("ovf_last_addr", wr_addr_q[wr_addr_q.size()-1], 16'h000F);
        check("ovf_last_data", wr_data_q[wr_data_q.size()-1], 16'hA00F);
        check("ovf_timing", late_err, 0);
        check("ovf_checksum", ld_checksum, exp_cs16);
        check("ovf_err_sticky", load_err, 1'b1);
        pulse_load();
        check("ovf_err_cleared", load_err, 1'b0);
        check("ovf_reload_state", state, 2'd1);
        send_word(16'h0BAD, 1'b1, acc);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("ovf_reload_done", state, 2'd0);

        // Run: free-run, jump vs branch, stall
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("run_state", state, 2'd2);
        check("run_fetch_valid", fetch_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("run_pc", pc, i);
            check("run_pc_plus1", pc_plus1, i + 1);
            tick();
        end
        jump = 1'b1; jump_target = 16'd9;
        branch_taken = 1'b1; branch_target = 16'd2;
        tick();
        jump = 1'b0; branch_taken = 1'b0;
        check("jump_wins", pc, 16'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", pc, 16'd9);
        end
        stall = 1'b0;
        branch_taken = 1'b1; branch_target = 16'h0020;
        tick();
        branch_taken = 1'b0;
        check("branch_out_of_range", pc, 16'h0020);
        jump = 1'b1; jump_target = 16'hFFFF;
        tick();
        jump = 1'b0;
        check("wrap_pc_plus1", pc_plus1, 16'h0000);
        tick();
        check("wrap_pc", pc, 16'h0000);

        // Halt with stall at pc=4, resume, load_start ignored in RUN
        jump = 1'b1; jump_target = 16'd4;
        tick();
        jump = 1'b0;
        halt_req = 1'b1; stall = 1'b1;
        tick();
        halt_req = 1'b0; stall = 1'b0;
        check("halt_state", state, 2'd3);
        check("halt_pc", pc, 16'd4);
        check("halt_fetch_valid", fetch_valid, 1'b0);
        tick();
        check("halt_pc_hold", pc, 16'd4);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("resume_state", state, 2'd2);
        check("resume_pc0", pc, 16'd4);
        tick();
        check("resume_pc1", pc, 16'd5);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("run_ignores_load", state, 2'd2);
        check("run_ignores_load_pc", pc, 16'd6);

        // Async reset mid-LOAD
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        load_start = 1'b1; run_start = 1'b1;
        tick();
        load_start = 1'b0; run_start = 1'b0;
        check("halt_load_priority", state, 2'd1);
        ld_data = 16'h5555; ld_valid = 1'b1;
        tick();
        check("pre_rst_we", imem_we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", imem_we, 1'b0);
        check("arst_state", state, 2'd0);
        check("arst_pc", pc, 16'h0);
        check("arst_ready", ld_ready, 1'b0);
        check("arst_fetch_valid", fetch_valid, 1'b0);
        check("arst_checksum", ld_checksum, 16'h0);
        clear_log();
        ld_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("arst_no_write", wr_addr_q.size(), 0);
        check("arst_state_after", state, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
